// File: rtl/sentinel_auth_sequencer.sv
// sentinel_auth_sequencer: four-byte authorization sequencer with gap timeout,
// consecutive-failure tracking and an optional lockout period.
// Optional feature macro: SENTINEL_LOCKOUT_EN (defined = lockout after
// MAX_FAILS consecutive failures; undefined = no LOCKOUT state, FAIL -> IDLE).
module sentinel_auth_sequencer #(
  parameter logic [31:0] KEY            = 32'hB6C15A3E,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 16,
  parameter int          GAP_TIMEOUT    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  output logic       key_ready,
  input  logic       clear,
  output logic       verified,
  output logic       locked_out,
  output logic       fail_pulse,
  output logic [1:0] fail_count,
  output logic [7:0] status
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COLLECT  = 3'd1;
  localparam logic [2:0] S_VERIFIED = 3'd2;
  localparam logic [2:0] S_FAIL     = 3'd3;
`ifdef SENTINEL_LOCKOUT_EN
  localparam logic [2:0] S_LOCKOUT  = 3'd4;
  localparam logic [1:0] MAX_FAILS_C = 2'(MAX_FAILS);
  localparam logic [7:0] LOCK_LOAD   = 8'(LOCKOUT_CYCLES - 1);
`endif
  localparam logic [7:0] GAP_LAST    = 8'(GAP_TIMEOUT - 1);

  logic [2:0] state;
  logic [2:0] state_next;
  logic [1:0] byte_idx;
  logic [1:0] byte_idx_next;
  logic       mismatch;
  logic       mismatch_next;
  logic [7:0] gap_cnt;
  logic [7:0] gap_cnt_next;
  logic [1:0] fail_count_next;
  logic       take;
  logic       byte_bad;
`ifdef SENTINEL_LOCKOUT_EN
  logic [7:0] lock_cnt;
  logic [7:0] lock_cnt_next;
`endif

  // Expected key byte at a given index, most significant byte first.
  function automatic logic [7:0] key_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    key_byte = KEY[31:24];
      2'd1:    key_byte = KEY[23:16];
      2'd2:    key_byte = KEY[15:8];
      2'd3:    key_byte = KEY[7:0];
      default: key_byte = KEY[31:24];
    endcase
  endfunction

  // Display code for each state.
  function automatic logic [7:0] state_code(input logic [2:0] s);
    case (s)
      S_IDLE:     state_code = 8'hA0;
      S_COLLECT:  state_code = 8'hA1;
      S_VERIFIED: state_code = 8'hC1;
      S_FAIL:     state_code = 8'hEE;
`ifdef SENTINEL_LOCKOUT_EN
      S_LOCKOUT:  state_code = 8'hFF;
`endif
      default:    state_code = 8'hA0;
    endcase
  endfunction

  // Saturating increment of the consecutive-failure counter.
  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    if (v == 2'd3) sat_inc = 2'd3;
    else           sat_inc = v + 2'd1;
  endfunction

  assign key_ready = ((state == S_IDLE) || (state == S_COLLECT)) && !clear;
  assign take      = key_valid && key_ready;
  // In IDLE byte_idx is always 0, so one comparator serves both states.
  assign byte_bad  = (key_data != key_byte(byte_idx));

  // Next-state and datapath decisions.
  always_comb begin
    state_next      = state;
    byte_idx_next   = byte_idx;
    mismatch_next   = mismatch;
    gap_cnt_next    = gap_cnt;
    fail_count_next = fail_count;
`ifdef SENTINEL_LOCKOUT_EN
    lock_cnt_next   = lock_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (take) begin
          state_next    = S_COLLECT;
          byte_idx_next = 2'd1;
          mismatch_next = byte_bad;
          gap_cnt_next  = 8'd0;
        end else begin
          byte_idx_next = 2'd0;
          mismatch_next = 1'b0;
          gap_cnt_next  = 8'd0;
        end
      end
      S_COLLECT: begin
        if (clear) begin
          // Abort: partial bytes discarded, not a failure.
          state_next    = S_IDLE;
          byte_idx_next = 2'd0;
          mismatch_next = 1'b0;
          gap_cnt_next  = 8'd0;
        end else if (take) begin
          gap_cnt_next = 8'd0;
          if (byte_idx == 2'd3) begin
            byte_idx_next = 2'd0;
            mismatch_next = 1'b0;
            if (mismatch || byte_bad) begin
              state_next      = S_FAIL;
              fail_count_next = sat_inc(fail_count);
            end else begin
              state_next      = S_VERIFIED;
              fail_count_next = 2'd0;
            end
          end else begin
            byte_idx_next = byte_idx + 2'd1;
            mismatch_next = mismatch || byte_bad;
          end
        end else if (gap_cnt == GAP_LAST) begin
          state_next      = S_FAIL;
          fail_count_next = sat_inc(fail_count);
          byte_idx_next   = 2'd0;
          mismatch_next   = 1'b0;
          gap_cnt_next    = 8'd0;
        end else begin
          gap_cnt_next = gap_cnt + 8'd1;
        end
      end
      S_VERIFIED: begin
        if (clear) state_next = S_IDLE;
        else       state_next = S_VERIFIED;
      end
      S_FAIL: begin
`ifdef SENTINEL_LOCKOUT_EN
        if (fail_count == MAX_FAILS_C) begin
          state_next    = S_LOCKOUT;
          lock_cnt_next = LOCK_LOAD;
        end else begin
          state_next = S_IDLE;
        end
`else
        state_next = S_IDLE;
`endif
      end
`ifdef SENTINEL_LOCKOUT_EN
      S_LOCKOUT: begin
        // clear is deliberately ignored for the whole lockout.
        if (lock_cnt == 8'd0) begin
          state_next      = S_IDLE;
          fail_count_next = 2'd0;
        end else begin
          lock_cnt_next = lock_cnt - 8'd1;
        end
      end
`endif
      default: begin
        state_next    = S_IDLE;
        byte_idx_next = 2'd0;
        mismatch_next = 1'b0;
        gap_cnt_next  = 8'd0;
      end
    endcase
  end

  // State, counters and registered outputs (derived from the next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_idx   <= 2'd0;
      mismatch   <= 1'b0;
      gap_cnt    <= 8'd0;
      fail_count <= 2'd0;
      verified   <= 1'b0;
      locked_out <= 1'b0;
      fail_pulse <= 1'b0;
      status     <= 8'hA0;
`ifdef SENTINEL_LOCKOUT_EN
      lock_cnt   <= 8'd0;
`endif
    end else begin
      state      <= state_next;
      byte_idx   <= byte_idx_next;
      mismatch   <= mismatch_next;
      gap_cnt    <= gap_cnt_next;
      fail_count <= fail_count_next;
      verified   <= (state_next == S_VERIFIED);
      fail_pulse <= (state_next == S_FAIL);
      status     <= state_code(state_next);
`ifdef SENTINEL_LOCKOUT_EN
      locked_out <= (state_next == S_LOCKOUT);
      lock_cnt   <= lock_cnt_next;
`else
      locked_out <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/sentinel_auth_sequencer.md
SENTINEL_AUTH_SEQUENCER -- requirements
Module: sentinel_auth_sequencer

Interface
REQ-001 Parameter KEY, default 32'hB6_C1_5A_3E; four-byte authorization sequence, most significant byte entered first.
REQ-002 Parameter MAX_FAILS, default 3; consecutive failures that trigger lockout (range 1..3).
REQ-003 Parameter LOCKOUT_CYCLES, default 16; lockout duration in clocks (range 1..255).
REQ-004 Parameter GAP_TIMEOUT, default 32; maximum idle clocks between bytes while collecting (range 1..255).
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset; one clock domain only.
REQ-007 key_valid  input  1  key byte offered this cycle.
REQ-008 key_data  input  8  offered key byte.
REQ-009 key_ready  output  1  sequencer accepts a byte; transfer occurs when key_valid && key_ready.
REQ-010 clear  input  1  relock / abort request.
REQ-011 verified  output  1  authorization granted.
REQ-012 locked_out  output  1  lockout in progress.
REQ-013 fail_pulse  output  1  one-cycle strobe per failed attempt.
REQ-014 fail_count  output  2  consecutive failed attempts since the last success or lockout.
REQ-015 status  output  8  state code for the display port.

Function
REQ-016 FSM states: IDLE, COLLECT, VERIFIED, FAIL, LOCKOUT; all outputs registered except key_ready.
REQ-017 key_ready = (state==IDLE || state==COLLECT) && !clear.
REQ-018 IDLE: first accepted byte -> COLLECT, byte index=1, mismatch flag = (byte != KEY[31:24]).
REQ-019 COLLECT: each accepted byte is compared with KEY at its index and ORed into the mismatch flag; comparison never exits early, so every attempt consumes exactly 4 bytes.
REQ-020 On acceptance of the 4th byte: no mismatch -> VERIFIED, any mismatch -> FAIL; verified asserts on the clock edge following that acceptance.
REQ-021 COLLECT gap counter resets on each accepted byte; reaching GAP_TIMEOUT clocks with no transfer -> FAIL.
REQ-022 FAIL lasts one cycle: fail_pulse=1, fail_count increments and saturates at 3. Next state is LOCKOUT if the incremented count == MAX_FAILS, otherwise IDLE.
REQ-023 LOCKOUT: counter loads LOCKOUT_CYCLES-1 and decrements to 0, then -> IDLE with fail_count=0; clear is ignored.
REQ-024 VERIFIED: verified=1 and fail_count=0, both set on entry; state holds until clear, then -> IDLE with verified=0 next cycle.
REQ-025 clear in COLLECT -> IDLE, partial bytes discarded, not counted as failure.
REQ-026 clear and key_valid in the same cycle: clear wins, the byte is not transferred.
REQ-027 status codes: IDLE 8'hA0, COLLECT 8'hA1, VERIFIED 8'hC1, FAIL 8'hEE, LOCKOUT 8'hFF.
REQ-028 status = 8'hC1 only while verified=1.

Reset
REQ-029 rst asserted at any time, including mid-COLLECT or mid-LOCKOUT, forces IDLE immediately; all counters cleared.
REQ-030 Reset values: verified=0, locked_out=0, fail_pulse=0, fail_count=0, status=8'hA0.
REQ-031 key_ready = 1 while in reset-released IDLE.

Configuration
REQ-032 Macro SENTINEL_LOCKOUT_EN defined: lockout behaviour per REQ-022/REQ-023.
REQ-033 Macro SENTINEL_LOCKOUT_EN undefined: LOCKOUT state and its counter are not compiled in; FAIL always -> IDLE; locked_out tied 0; fail_count still increments and saturates.

Verification
REQ-034 Reset, then bytes B6,C1,5A,3E on consecutive cycles -> verified=1 and status=C1 one cycle after the 4th byte; fail_count=0.
REQ-035 Bytes B6,00,5A,3E -> no early abort, all 4 bytes accepted, then fail_pulse for 1 cycle, fail_count=1, status EE then A0.
REQ-036 Three wrong 4-byte attempts with SENTINEL_LOCKOUT_EN defined -> locked_out=1, key_ready=0, status FF for 16 cycles, then IDLE with fail_count=0.
REQ-037 B6,C1 accepted, then 32 idle cycles -> timeout FAIL, fail_count=1.
REQ-038 B6 accepted, then clear and key_valid asserted in the same cycle -> IDLE, byte not accepted, fail_count unchanged.
REQ-039 rst pulsed mid-LOCKOUT -> immediate IDLE, status A0, locked_out=0.
